// File: rtl/nand_bus_sequencer.sv
// nand_bus_sequencer
//   Sequences one NAND operation (page read, page program or block erase)
//   across a multiplexed command/address/data bus shared by NumChips devices.
//   The bidirectional DIO is split into dioOut/dioOe/dioIn for a pad wrapper.
//
// Ports
//   clk, rstN                  system clock, async active-low reset
//   reqValid/reqReady          operation request handshake (ready only in IDLE)
//   reqOp, reqChip, reqAddr    operation, target chip, address (slice 0 first)
//   wrValid/wrReady, wrData    program data handshake
//   rdValid, rdData            read data strobe (no backpressure)
//   done, error                one-cycle completion pulse and its status
//   dioOut, dioOe, dioIn       split bus
//   ALE, CLE, wEn, rEn         active-high latch and strobe lines
//   cEn                        one-hot chip enable
//   status                     per-chip ready lines
//
// Optional feature: define NAND_SEQ_TIMEOUT_EN to bound the ready wait to
// TimeoutCycles cycles; expiry ends the operation with error=1.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; reqReady=1
// CMD1    | first command beat (0x00 / 0x80 / 0x60)
// ADDR    | AddrCycles address beats
// WDATA   | DataBeats program beats, stalls in phase A until wrValid
// CMD2    | confirm command beat (0x30 / 0x10 / 0xD0)
// WAITB   | BusyDelay cycles before status is trusted
// WAITRDY | waiting for status[chip]
// RDATA   | DataBeats read beats
// DONE    | done pulse, then IDLE

module nand_bus_sequencer #(
  parameter int DIOWidth      = 16,
  parameter int NumChips      = 4,
  parameter int AddrCycles    = 3,
  parameter int DataBeats     = 4,
  parameter int BusyDelay     = 2,
  parameter int TimeoutCycles = 1024,
  localparam int CW = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           reqValid,
  output logic                           reqReady,
  input  logic [1:0]                     reqOp,
  input  logic [CW-1:0]                  reqChip,
  input  logic [AddrCycles*DIOWidth-1:0] reqAddr,
  input  logic                           wrValid,
  output logic                           wrReady,
  input  logic [DIOWidth-1:0]            wrData,
  output logic                           rdValid,
  output logic [DIOWidth-1:0]            rdData,
  output logic                           done,
  output logic                           error,
  output logic [DIOWidth-1:0]            dioOut,
  output logic                           dioOe,
  input  logic [DIOWidth-1:0]            dioIn,
  output logic                           ALE,
  output logic                           CLE,
  output logic                           wEn,
  output logic                           rEn,
  output logic [NumChips-1:0]            cEn,
  input  logic [NumChips-1:0]            status
);

  localparam int MaxBeats = (AddrCycles > DataBeats) ? AddrCycles : DataBeats;
  localparam int BW       = $clog2(MaxBeats + 1);
  localparam int WW       = (BusyDelay > 1) ? $clog2(BusyDelay) : 1;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_PROG = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD1, S_ADDR, S_WDATA, S_CMD2, S_WAITB, S_WAITRDY, S_RDATA, S_DONE
  } state_t;

  state_t                         state, state_nx;
  logic                           ph, ph_nx;          // 0 = strobe phase, 1 = hold phase
  logic [BW-1:0]                  cnt, cnt_nx;
  logic [WW-1:0]                  wcnt, wcnt_nx;
  logic                           err_q, err_nx;
  logic [1:0]                     op_q;
  logic [CW-1:0]                  chip_q;
  logic [AddrCycles*DIOWidth-1:0] addr_q;
  logic [DIOWidth-1:0]            dout_q, dout_v, rd_q;
  logic [7:0]                     cmd1, cmd2;
  logic                           cen_on, illegal, to_hit;

  assign illegal = (reqOp == OP_RSVD) || (32'(reqChip) >= NumChips);

  always_comb begin
    cmd1 = 8'h00;
    cmd2 = 8'h00;
    case (op_q)
      2'b00:   begin cmd1 = 8'h00; cmd2 = 8'h30; end
      2'b01:   begin cmd1 = 8'h80; cmd2 = 8'h10; end
      2'b10:   begin cmd1 = 8'h60; cmd2 = 8'hD0; end
      default: begin cmd1 = 8'h00; cmd2 = 8'h00; end
    endcase
  end

`ifdef NAND_SEQ_TIMEOUT_EN
  localparam int TOW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [TOW-1:0] to_cnt;

  // Held at zero outside WAITRDY, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                   to_cnt <= '0;
    else if (state != S_WAITRDY) to_cnt <= '0;
    else                         to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (to_cnt == TOW'(TimeoutCycles - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= S_IDLE;
      ph     <= 1'b0;
      cnt    <= '0;
      wcnt   <= '0;
      err_q  <= 1'b0;
      op_q   <= 2'b00;
      chip_q <= '0;
      addr_q <= '0;
      dout_q <= '0;
      rd_q   <= '0;
    end else begin
      state <= state_nx;
      ph    <= ph_nx;
      cnt   <= cnt_nx;
      wcnt  <= wcnt_nx;
      err_q <= err_nx;
      if (state == S_IDLE && reqValid) begin
        op_q   <= reqOp;
        chip_q <= reqChip;
        addr_q <= reqAddr;
      end
      // Last driven word, replayed during phase B and write stalls.
      if (dioOe) dout_q <= dout_v;
      if (state == S_RDATA && !ph) rd_q <= dioIn;
    end
  end

  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    cnt_nx   = cnt;
    wcnt_nx  = wcnt;
    err_nx   = err_q;
    reqReady = 1'b0;
    wrReady  = 1'b0;
    rdValid  = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    dout_v   = '0;
    dioOe    = 1'b0;
    ALE      = 1'b0;
    CLE      = 1'b0;
    wEn      = 1'b0;
    rEn      = 1'b0;
    cen_on   = 1'b0;
    case (state)
      S_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          ph_nx  = 1'b0;
          cnt_nx = '0;
          err_nx = illegal;
          state_nx = illegal ? S_DONE : S_CMD1;
        end
      end
      S_CMD1: begin
        cen_on = 1'b1;
        CLE    = 1'b1;
        dioOe  = 1'b1;
        wEn    = !ph;
        dout_v = DIOWidth'(cmd1);
        ph_nx  = !ph;
        if (ph) state_nx = S_ADDR;
      end
      S_ADDR: begin
        cen_on = 1'b1;
        ALE    = 1'b1;
        dioOe  = 1'b1;
        wEn    = !ph;
        dout_v = addr_q[32'(cnt)*DIOWidth +: DIOWidth];
        ph_nx  = !ph;
        if (ph) begin
          if (cnt == BW'(AddrCycles - 1)) begin
            cnt_nx   = '0;
            state_nx = (op_q == OP_PROG) ? S_WDATA : S_CMD2;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_WDATA: begin
        cen_on = 1'b1;
        dioOe  = 1'b1;
        dout_v = dout_q;
        if (!ph) begin
          wrReady = 1'b1;
          if (wrValid) begin
            wEn    = 1'b1;
            dout_v = wrData;
            ph_nx  = 1'b1;
          end
        end else begin
          ph_nx = 1'b0;
          if (cnt == BW'(DataBeats - 1)) begin
            cnt_nx   = '0;
            state_nx = S_CMD2;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_CMD2: begin
        cen_on = 1'b1;
        CLE    = 1'b1;
        dioOe  = 1'b1;
        wEn    = !ph;
        dout_v = DIOWidth'(cmd2);
        ph_nx  = !ph;
        if (ph) begin
          wcnt_nx  = WW'(BusyDelay - 1);
          state_nx = S_WAITB;
        end
      end
      S_WAITB: begin
        cen_on = 1'b1;
        if (wcnt == '0) state_nx = S_WAITRDY;
        else            wcnt_nx  = wcnt - 1'b1;
      end
      S_WAITRDY: begin
        cen_on = 1'b1;
        if (status[chip_q]) begin
          ph_nx    = 1'b0;
          cnt_nx   = '0;
          state_nx = (op_q == OP_READ) ? S_RDATA : S_DONE;
        end else if (to_hit) begin
          err_nx   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_RDATA: begin
        cen_on  = 1'b1;
        rEn     = !ph;
        rdValid = ph;
        ph_nx   = !ph;
        if (ph) begin
          if (cnt == BW'(DataBeats - 1)) state_nx = S_DONE;
          else                           cnt_nx   = cnt + 1'b1;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        error    = err_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cEn = '0;
    if (cen_on) cEn[chip_q] = 1'b1;
  end

  assign dioOut = dout_v;
  assign rdData = rd_q;

endmodule
